call_register: RTL



---
 rtl/elevator_pkg.sv | 21 ++
 rtl/call_register_if.sv | 24 ++
 rtl/button_debounce.sv | 54 +++++
 rtl/call_register.sv | 79 +++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants and types: floor count, request bit ordering, engine encoding.
package elevator_pkg;

    // Number of served floors; bit i of every floor vector is floor i+1, MSB = top floor.
    localparam int unsigned FLOORS = 3;

    typedef logic [FLOORS-1:0] floor_vec_t;

    // Engine command encoding shared with the movement FSM.
    typedef enum logic [1:0] {
        ENG_OFF  = 2'b00,
        ENG_UP   = 2'b10,
        ENG_DOWN = 2'b11
    } engine_e;

    // True when at least one floor bit is set.
    function automatic logic any_floor(input floor_vec_t v);
        return |v;
    endfunction

endpackage

// File: rtl/call_register_if.sv
// Panel/door inputs and latched request outputs of the call register.
interface call_register_if;
    import elevator_pkg::*;

    floor_vec_t interior_panel;
    floor_vec_t exterior_panel;
    floor_vec_t doors;
    floor_vec_t requests;
    logic       any_request;
    logic       new_call;

    // Upstream side: drives buttons and door state, observes requests.
    modport master (
        output interior_panel, exterior_panel, doors,
        input  requests, any_request, new_call
    );

    // Call register side.
    modport slave (
        input  interior_panel, exterior_panel, doors,
        output requests, any_request, new_call
    );

endinterface

// File: rtl/button_debounce.sv
// One raw button bit: 2-flop synchroniser, stable-count debounce, rising-edge detect.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic rise_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounced level, previous level and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_c = deb_q & ~prev_q;

endmodule

// File: rtl/call_register.sv
// Latches debounced button presses into per-floor requests, cleared by an open door.
module call_register
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic            FRQ,
    input  logic            RST,
    call_register_if.slave  bus
);

    floor_vec_t int_rise;
    floor_vec_t ext_rise;
    floor_vec_t press;
    floor_vec_t requests_q;
    floor_vec_t requests_d;
    logic       new_call_q;
    logic       new_call_d;
    logic       any_request_q;
    logic       any_request_d;

    // One debouncer per interior and per exterior button.
    for (genvar i = 0; i < int'(FLOORS); i++) begin : g_floor
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_int_deb (
            .clk_i  (FRQ),
            .rst_i  (RST),
            .raw_i  (bus.interior_panel[i]),
            .rise_c (int_rise[i])
        );

        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ext_deb (
            .clk_i  (FRQ),
            .rst_i  (RST),
            .raw_i  (bus.exterior_panel[i]),
            .rise_c (ext_rise[i])
        );
    end

    assign press = int_rise | ext_rise;

    // Open door clears (and swallows a simultaneous press), else a press sets.
    always_comb begin
        requests_d = requests_q;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (bus.doors[i]) begin
                requests_d[i] = 1'b0;
            end else if (press[i]) begin
                requests_d[i] = 1'b1;
            end
        end
        new_call_d    = |(requests_d & ~requests_q);
        any_request_d = any_floor(requests_d);
    end

    // Output registers.
    always_ff @(posedge FRQ) begin
        if (RST) begin
            requests_q    <= '0;
            new_call_q    <= 1'b0;
            any_request_q <= 1'b0;
        end else begin
            requests_q    <= requests_d;
            new_call_q    <= new_call_d;
            any_request_q <= any_request_d;
        end
    end

    assign bus.requests    = requests_q;
    assign bus.new_call    = new_call_q;
    assign bus.any_request = any_request_q;

endmodule
